// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard unit: destination-tag pipeline entries and helpers.
package fwd_pkg;

    localparam int unsigned PKG_REG_W   = 5;
    localparam int unsigned PKG_MAX_SRC = 2;

    localparam logic [PKG_REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [PKG_REG_W-1:0] rd;
        logic                 we;
        logic                 is_load;
    } stage_entry_t;

    typedef struct packed {
        logic [PKG_MAX_SRC-1:0][PKG_REG_W-1:0] rs;
        logic [PKG_MAX_SRC-1:0]                used;
        stage_entry_t                          dst;
    } ex_entry_t;

    // x0 is hardwired, so a write to it never produces a forwardable value.
    function automatic logic entry_match(stage_entry_t e, logic [PKG_REG_W-1:0] src,
                                         logic used);
        return e.we && (e.rd != REG_ZERO) && used && (e.rd == src);
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Single-source priority matcher: finds the youngest matching entry and flags
// whether it is a load whose data is not yet available at that position.
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned STG_W    = 1
) (
    input  logic [PKG_REG_W-1:0]  src,
    input  logic                  src_used,
    input  stage_entry_t [DEPTH-1:0] entries,
    output logic                  hit,
    output logic [STG_W-1:0]      idx,
    output logic                  not_ready
);

    always_comb begin
        hit       = 1'b0;
        idx       = '0;
        not_ready = 1'b0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (!hit && entry_match(entries[j], src, src_used)) begin
                hit       = 1'b1;
                idx       = STG_W'(j);
                not_ready = entries[j].is_load && (j < LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks destination tags from ID/EX through
// FWD_DEPTH post-EX stages, drives EX forward selects, ID stall and a stall counter.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned FWD_DEPTH = 2,
    parameter int unsigned LOAD_LAT  = 1,
    parameter int unsigned REG_W     = 5,
    parameter int unsigned STG_W     = $clog2(FWD_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       id_valid,
    input  logic [NUM_SRC*REG_W-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]         id_rs_used,
    input  logic [REG_W-1:0]           id_rd,
    input  logic                       id_rd_we,
    input  logic                       id_is_load,
    input  logic                       flush_ex,
    input  logic                       ext_stall,
    output logic                       stall_id,
    output logic [NUM_SRC-1:0]         fwd_en,
    output logic [NUM_SRC*STG_W-1:0]   fwd_stage,
    output logic                       fwd_err,
    output logic [31:0]                stall_cnt
);

    if (LOAD_LAT < 1 || LOAD_LAT >= FWD_DEPTH) begin : g_bad_load_lat
        $error("fwd_hazard_unit: LOAD_LAT must satisfy 1 <= LOAD_LAT < FWD_DEPTH");
    end
    if (REG_W != PKG_REG_W || NUM_SRC > PKG_MAX_SRC) begin : g_bad_shape
        $error("fwd_hazard_unit: REG_W/NUM_SRC do not fit the fwd_pkg entry types");
    end

    stage_entry_t [FWD_DEPTH-1:0] stg_q, stg_d;
    stage_entry_t [FWD_DEPTH-1:0] id_ent;
    ex_entry_t                    ex_q, ex_d;
    logic [31:0]                  stall_cnt_q, stall_cnt_d;

    logic [NUM_SRC-1:0] ex_hit, ex_nr, id_hit, id_nr;
    logic [STG_W-1:0]   ex_idx [NUM_SRC];
    logic [STG_W-1:0]   id_idx [NUM_SRC];

    // ID looks one cycle ahead: EX entry lands at index 0, stage k at k+1.
    always_comb begin
        id_ent[0] = ex_q.dst;
        for (int unsigned k = 1; k < FWD_DEPTH; k++) begin
            id_ent[k] = stg_q[k-1];
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_src_match #(
            .DEPTH    (FWD_DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .STG_W    (STG_W)
        ) u_ex_match (
            .src       (ex_q.rs[s]),
            .src_used  (ex_q.used[s]),
            .entries   (stg_q),
            .hit       (ex_hit[s]),
            .idx       (ex_idx[s]),
            .not_ready (ex_nr[s])
        );

        fwd_src_match #(
            .DEPTH    (FWD_DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .STG_W    (STG_W)
        ) u_id_match (
            .src       (id_rs[s*REG_W +: REG_W]),
            .src_used  (id_rs_used[s]),
            .entries   (id_ent),
            .hit       (id_hit[s]),
            .idx       (id_idx[s]),
            .not_ready (id_nr[s])
        );
    end

    always_comb begin
        fwd_en    = '0;
        fwd_stage = '0;
        fwd_err   = 1'b0;
        stall_id  = 1'b0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (ex_hit[s]) begin
                if (ex_nr[s]) begin
                    fwd_err = 1'b1;
                end else begin
                    fwd_en[s]                  = 1'b1;
                    fwd_stage[s*STG_W +: STG_W] = ex_idx[s];
                end
            end
            if (id_valid && id_hit[s] && id_nr[s]) begin
                stall_id = 1'b1;
            end
        end
    end

    always_comb begin
        stg_d       = stg_q;
        ex_d        = ex_q;
        stall_cnt_d = stall_cnt_q;
        if (!ext_stall) begin
            stg_d[0] = ex_q.dst;
            for (int unsigned k = 1; k < FWD_DEPTH; k++) begin
                stg_d[k] = stg_q[k-1];
            end
            ex_d = '0;
            if (id_valid && !stall_id && !flush_ex) begin
                for (int unsigned s = 0; s < NUM_SRC; s++) begin
                    ex_d.rs[s] = id_rs[s*REG_W +: REG_W];
                end
                ex_d.used[NUM_SRC-1:0] = id_rs_used;
                ex_d.dst.rd            = id_rd;
                ex_d.dst.we            = id_rd_we;
                ex_d.dst.is_load       = id_is_load;
            end
            if (stall_id && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_q       <= '0;
            ex_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            stg_q       <= stg_d;
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the pipelined RISC-V core; successor to the two-stage combinational forward selector.
- Owns its own pipeline of destination tags: ID/EX source/dest entry, then FWD_DEPTH post-EX stages.
- Produces per-source forward selects for the EX stage, a load-use stall for ID, and a stall-cycle performance counter.
- Sits beside the ID/EX/MEM/WB pipeline registers; datapath muxes consume its outputs.

Parameters:
- NUM_SRC, 2, number of register read ports per instruction.
- FWD_DEPTH, 2, number of post-EX stages tracked; stage 0 = EX/MEM, stage 1 = MEM/WB, and so on.
- LOAD_LAT, 1, first post-EX stage index at which load data can be forwarded; must satisfy 1 <= LOAD_LAT < FWD_DEPTH (elaboration error otherwise).
- REG_W, 5, register address width.
- STG_W, $clog2(FWD_DEPTH), width of the stage index.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  NUM_SRC*REG_W  ID source addresses, port i at [i*REG_W +: REG_W].
- id_rs_used  in  NUM_SRC  source i is actually read.
- id_rd  in  REG_W  ID destination.
- id_rd_we  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- flush_ex  in  1  kill the instruction entering EX (taken branch).
- ext_stall  in  1  freeze the whole pipeline (memory wait).
- stall_id  out  1  hold PC and IF/ID; insert a bubble into EX.
- fwd_en  out  NUM_SRC  source i takes a forwarded value.
- fwd_stage  out  NUM_SRC*STG_W  stage index forwarded for source i.
- fwd_err  out  1  EX source matched a load whose data is not ready (protocol violation).
- stall_cnt  out  32  saturating count of cycles with stall_id=1.

Behaviour:
- Reset (rst_n=0, async): EX entry and all stages invalid (we=0, rd=0, load=0); stall_cnt=0. With all entries invalid, every output reads 0.
- Advance (ext_stall=0) at each posedge:
  - stage[k] <= stage[k-1];
  - stage[0] <= EX entry {rd, we, load};
  - EX entry <= bubble if (!id_valid || stall_id || flush_ex), else the ID fields {rs, rs_used, rd, rd_we, is_load}.
- ext_stall=1: all entries hold and stall_cnt holds. stall_id is still computed from the current state.
- Match rule: an entry matches source s only if entry.we=1, entry.rd != 0, s.used=1, and entry.rd == s.
- EX forwarding (combinational):
  - For each EX source, search stages 0..FWD_DEPTH-1; the youngest (lowest index) match wins.
  - If the winner is non-load, or a load at index >= LOAD_LAT: fwd_en=1 and fwd_stage=index.
  - If the winner is a load at index < LOAD_LAT: fwd_en=0 and fwd_err=1. Older matches are never used to bypass a younger one.
  - No match: fwd_en=0, fwd_stage=0; the datapath uses its default operand select.
- stall_id (combinational) = id_valid && any used ID source matches a load that will not be ready next cycle:
  - the EX entry, whose next index is 0 (0 < LOAD_LAT, so always stalls); or
  - stage k with k+1 < LOAD_LAT.
- Load-use stall length: exactly LOAD_LAT cycles (excluding ext_stall cycles).
- flush_ex and stall_id together: flush wins. The bubble is inserted either way; stall_id still reflects the hazard.
- stall_cnt increments when stall_id=1 and ext_stall=0; saturates at 0xFFFF_FFFF.
- Reset asserted mid-operation: all tracking is dropped immediately; no stale forward after release.

Decomposition:
- Shared package fwd_pkg:
  - typedef stage_entry_t {rd, we, is_load};
  - typedef ex_entry_t (adds rs array and used bits);
  - localparam REG_ZERO.
- One natural sub-module, fwd_src_match: a single-source priority matcher over the stage array, returning {hit, idx, not_ready}. It is instantiated NUM_SRC times for EX forwarding and NUM_SRC times for ID stall detection.

Test Plan:
- Reset, then a non-load writes x5; the next instruction reads rs1=x5 -> cycle after issue: fwd_en[0]=1, fwd_stage=0; one cycle later, if re-read: fwd_stage=1.
- Back-to-back writes to x7 by instructions A then B; C reads x7 -> fwd_stage=0 (B wins over A).
- LOAD_LAT=1: lw x3 then add reading x3 -> stall_id=1 for exactly 1 cycle, one bubble in EX, then fwd_en=1, fwd_stage=1, fwd_err=0, stall_cnt=1.
- LOAD_LAT=2, FWD_DEPTH=3: same sequence -> stall_id high 2 cycles, then fwd_stage=2, stall_cnt=2.
- Write to x0, then read x0 -> fwd_en=0, stall_id=0; a load to x0 followed by a use -> no stall.
- Load then use with ext_stall=1 for 3 cycles mid-stall -> entries frozen, stall_id stays 1, stall_cnt unchanged during the freeze; flush_ex on the issuing cycle -> entry becomes a bubble with no later forward; rst_n pulsed low mid-sequence -> all outputs 0 at once.
